// File: rtl/csi_pkg.sv
// csi_pkg: shared CSI-2 packet constants for the packet parser and header ECC.
// Holds data-type codes, header field offsets/widths and parser state encodings.
// No ports; imported with import csi_pkg::*.
package csi_pkg;

  // Short-packet data types
  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

  // Header layout: DI=[7:0] (VC=[7:6], DT=[5:0]), WC=[23:8], ECC=[31:24]
  localparam int HDR_DT_LSB  = 0;
  localparam int HDR_DT_W    = 6;
  localparam int HDR_VC_LSB  = 6;
  localparam int HDR_VC_W    = 2;
  localparam int HDR_WC_LSB  = 8;
  localparam int HDR_WC_W    = 16;
  localparam int HDR_ECC_LSB = 24;
  localparam int HDR_PROT_W  = 24;  // bits covered by the ECC
  localparam int ECC_W       = 6;

  // Remaining-byte counter: WC + 2 CRC bytes needs 17 bits
  localparam int REM_W = 17;

  // Parser states
  localparam logic [0:0] ST_WAIT    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

endpackage

// File: rtl/csi_header_ecc.sv
// csi_header_ecc: CSI-2 6-bit Hamming ECC over the 24 protected header bits.
// Ports: i_hdr [23:0] header DI+WC, o_ecc [5:0] computed parity. Purely combinational.
// Only instantiated when CSI_ECC_CHECK_EN is defined.
module csi_header_ecc
  import csi_pkg::*;
(
  input  logic [HDR_PROT_W-1:0] i_hdr,
  output logic [ECC_W-1:0]      o_ecc
);

  // Each parity bit is the XOR of the header bits selected by its mask.
  localparam logic [HDR_PROT_W-1:0] P0_MASK = 24'hF12CB7;
  localparam logic [HDR_PROT_W-1:0] P1_MASK = 24'hF2555B;
  localparam logic [HDR_PROT_W-1:0] P2_MASK = 24'h749A6D;
  localparam logic [HDR_PROT_W-1:0] P3_MASK = 24'hB8E38E;
  localparam logic [HDR_PROT_W-1:0] P4_MASK = 24'hDF03F0;
  localparam logic [HDR_PROT_W-1:0] P5_MASK = 24'hEFFC00;

  assign o_ecc[0] = ^(i_hdr & P0_MASK);
  assign o_ecc[1] = ^(i_hdr & P1_MASK);
  assign o_ecc[2] = ^(i_hdr & P2_MASK);
  assign o_ecc[3] = ^(i_hdr & P3_MASK);
  assign o_ecc[4] = ^(i_hdr & P4_MASK);
  assign o_ecc[5] = ^(i_hdr & P5_MASK);

endmodule

// File: rtl/csi_packet_parser.sv
// csi_packet_parser: decodes CSI-2 packet headers from the word combiner, tracks
// long-packet length and emits payload words with byte counts and a last flag.
// Ports: i_clock/i_reset(sync, high)/i_enable, i_data/i_data_enable/i_data_frame
// from the combiner; o_wait_for_sync/o_packet_done back to it; o_payload* stream;
// o_data_type/o_word_count/o_vsync/o_in_frame/o_in_line status; o_err_abort/o_err_ecc.
// Latency: header fields and short-packet done 1 cycle; payload 1 cycle, 2 when the
// last payload word waits for a CRC-only word. Optional macro: CSI_ECC_CHECK_EN.
module csi_packet_parser
  import csi_pkg::*;
#(
  parameter logic [1:0] VC = 2'd0
)
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [31:0] i_data,
  input  logic        i_data_enable,
  input  logic        i_data_frame,
  output logic        o_wait_for_sync,
  output logic        o_packet_done,
  output logic [31:0] o_payload,
  output logic        o_payload_enable,
  output logic [2:0]  o_payload_bytes,
  output logic        o_payload_last,
  output logic [5:0]  o_data_type,
  output logic [15:0] o_word_count,
  output logic        o_vsync,
  output logic        o_in_frame,
  output logic        o_in_line,
  output logic        o_err_abort,
  output logic        o_err_ecc
);

  logic [0:0]       r_state;
  logic [REM_W-1:0] r_remaining;
  logic             r_vc_hit;
  logic             r_hold_vld;
  logic [31:0]      r_hold_dat;
  logic [2:0]       r_hold_bytes;
  logic             r_packet_done, r_payload_enable, r_payload_last;
  logic [31:0]      r_payload;
  logic [2:0]       r_payload_bytes;
  logic [5:0]       r_data_type;
  logic [15:0]      r_word_count;
  logic             r_vsync, r_in_frame, r_in_line, r_err_abort, r_err_ecc;

  logic [HDR_DT_W-1:0] w_dt;
  logic [HDR_VC_W-1:0] w_vc;
  logic [HDR_WC_W-1:0] w_wc;
  logic                w_vc_hit;
  logic                w_ecc_ok;
  logic [2:0]          w_pb;
  logic                w_final;
  logic                w_hold;
  logic [REM_W-1:0]    w_rem_next;

  assign w_dt     = i_data[HDR_DT_LSB +: HDR_DT_W];
  assign w_vc     = i_data[HDR_VC_LSB +: HDR_VC_W];
  assign w_wc     = i_data[HDR_WC_LSB +: HDR_WC_W];
  assign w_vc_hit = (w_vc == VC);

`ifdef CSI_ECC_CHECK_EN
  logic [ECC_W-1:0] w_ecc_calc;
  csi_header_ecc u_ecc (
    .i_hdr (i_data[HDR_PROT_W-1:0]),
    .o_ecc (w_ecc_calc)
  );
  assign w_ecc_ok = (w_ecc_calc == i_data[HDR_ECC_LSB +: ECC_W]);
`else
  assign w_ecc_ok = 1'b1;
`endif

  // Payload bytes in the current word: remaining minus the 2 CRC bytes, clamped to 0..4.
  always_comb begin
    w_pb = 3'd0;
    if (r_remaining >= 17'd6)
      w_pb = 3'd4;
    else if (r_remaining > 17'd2)
      w_pb = r_remaining[2:0] - 3'd2;
  end

  assign w_final    = (r_remaining <= 17'd4);
  assign w_rem_next = w_final ? '0 : r_remaining - 17'd4;
  // The word after this one holds only CRC, so this word is the last payload word but
  // is held until that CRC word confirms the packet completed.
  assign w_hold     = !w_final && (w_rem_next <= 17'd2);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= ST_WAIT;
      r_remaining      <= '0;
      r_vc_hit         <= 1'b0;
      r_hold_vld       <= 1'b0;
      r_hold_dat       <= '0;
      r_hold_bytes     <= '0;
      r_packet_done    <= 1'b0;
      r_payload_enable <= 1'b0;
      r_payload_last   <= 1'b0;
      r_payload        <= '0;
      r_payload_bytes  <= '0;
      r_data_type      <= '0;
      r_word_count     <= '0;
      r_vsync          <= 1'b0;
      r_in_frame       <= 1'b0;
      r_in_line        <= 1'b0;
      r_err_abort      <= 1'b0;
      r_err_ecc        <= 1'b0;
    end else if (i_enable) begin
      r_packet_done    <= 1'b0;
      r_payload_enable <= 1'b0;
      r_payload_last   <= 1'b0;
      r_vsync          <= 1'b0;
      r_err_abort      <= 1'b0;
      r_err_ecc        <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (i_data_frame && i_data_enable) begin
            if (!w_ecc_ok) begin
              // Rejected header: release the combiner, touch nothing else.
              r_err_ecc     <= 1'b1;
              r_packet_done <= 1'b1;
            end else begin
              r_data_type  <= w_dt;
              r_word_count <= w_wc;
              r_vc_hit     <= w_vc_hit;
              if (w_dt <= DT_SHORT_MAX) begin
                r_packet_done <= 1'b1;
                if (w_vc_hit) begin
                  case (w_dt)
                    DT_FS: begin
                      r_vsync    <= 1'b1;
                      r_in_frame <= 1'b1;
                    end
                    DT_FE:   r_in_frame <= 1'b0;
                    DT_LS:   r_in_line  <= 1'b1;
                    DT_LE:   r_in_line  <= 1'b0;
                    default: ;
                  endcase
                end
              end else begin
                r_remaining <= {1'b0, w_wc} + 17'd2;
                if (w_vc_hit)
                  r_in_line <= 1'b1;
                r_state <= ST_PAYLOAD;
              end
            end
          end
        end
        default: begin
          if (!i_data_frame) begin
            // Truncated packet: a held word is dropped, no last flag, no done.
            r_state     <= ST_WAIT;
            r_err_abort <= 1'b1;
            r_remaining <= '0;
            r_hold_vld  <= 1'b0;
          end else if (i_data_enable) begin
            r_remaining <= w_rem_next;
            if (r_hold_vld) begin
              // Only the CRC-only final word can follow a held word.
              r_hold_vld       <= 1'b0;
              r_payload_enable <= 1'b1;
              r_payload        <= r_hold_dat;
              r_payload_bytes  <= r_hold_bytes;
              r_payload_last   <= 1'b1;
            end else if ((w_pb != 3'd0) && r_vc_hit) begin
              if (w_hold) begin
                r_hold_vld   <= 1'b1;
                r_hold_dat   <= i_data;
                r_hold_bytes <= w_pb;
              end else begin
                r_payload_enable <= 1'b1;
                r_payload        <= i_data;
                r_payload_bytes  <= w_pb;
                r_payload_last   <= w_final;
              end
            end
            if (w_final) begin
              r_packet_done <= 1'b1;
              r_state       <= ST_WAIT;
              if (r_vc_hit)
                r_in_line <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign o_wait_for_sync  = (r_state == ST_WAIT);
  assign o_packet_done    = r_packet_done;
  assign o_payload        = r_payload;
  assign o_payload_enable = r_payload_enable;
  assign o_payload_bytes  = r_payload_bytes;
  assign o_payload_last   = r_payload_last;
  assign o_data_type      = r_data_type;
  assign o_word_count     = r_word_count;
  assign o_vsync          = r_vsync;
  assign o_in_frame       = r_in_frame;
  assign o_in_line        = r_in_line;
  assign o_err_abort      = r_err_abort;
  assign o_err_ecc        = r_err_ecc;

endmodule

// File: tb/tb_csi_packet_parser.sv
// tb_csi_packet_parser: directed bench for csi_packet_parser with VC=0.
// Drives combiner-style words one per step and checks registered outputs 1 time unit
// after each rising edge. Optional macro: CSI_ECC_CHECK_EN (adds ECC reject test).
module tb_csi_packet_parser;

  logic        clk = 1'b0;
  logic        rst, en, de, df;
  logic [31:0] dat;
  logic        wait_for_sync, packet_done, payload_enable, payload_last;
  logic        vsync, in_frame, in_line, err_abort, err_ecc;
  logic [31:0] payload;
  logic [2:0]  payload_bytes;
  logic [5:0]  data_type;
  logic [15:0] word_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csi_packet_parser #(.VC(2'd0)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_enable         (en),
    .i_data           (dat),
    .i_data_enable    (de),
    .i_data_frame     (df),
    .o_wait_for_sync  (wait_for_sync),
    .o_packet_done    (packet_done),
    .o_payload        (payload),
    .o_payload_enable (payload_enable),
    .o_payload_bytes  (payload_bytes),
    .o_payload_last   (payload_last),
    .o_data_type      (data_type),
    .o_word_count     (word_count),
    .o_vsync          (vsync),
    .o_in_frame       (in_frame),
    .o_in_line        (in_line),
    .o_err_abort      (err_abort),
    .o_err_ecc        (err_ecc)
  );

  // Reference CSI-2 header ECC, written out bit by bit.
  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] e;
    e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return e;
  endfunction

  function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                      input logic [15:0] wc);
    logic [23:0] p;
    p = {wc, vc, dt};
    return {2'b00, ecc_of(p), p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    dat = w;
    de  = 1'b1;
    df  = 1'b1;
    step();
  endtask

  task automatic idle();
    de = 1'b0;
    df = 1'b0;
    step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; de = 1'b0; df = 1'b0; dat = '0;
    step();
    step();
    // Reset state
    chk("rst_wait_for_sync", wait_for_sync, 1);
    chk("rst_packet_done",   packet_done, 0);
    chk("rst_payload_en",    payload_enable, 0);
    chk("rst_payload",       payload, 0);
    chk("rst_data_type",     data_type, 0);
    chk("rst_word_count",    word_count, 0);
    chk("rst_flags",         {vsync, in_frame, in_line, err_abort, err_ecc, payload_last}, 0);
    rst = 1'b0;
    step();

    // Frame start short packet
    send(32'h0000_0000);
    chk("fs_vsync",       vsync, 1);
    chk("fs_in_frame",    in_frame, 1);
    chk("fs_done",        packet_done, 1);
    chk("fs_wait",        wait_for_sync, 1);
    idle();
    chk("fs_vsync_end",   vsync, 0);
    chk("fs_done_end",    packet_done, 0);
    chk("fs_in_frame_hold", in_frame, 1);

    // Long DT 0x2A WC=6: 4 bytes, then 2 bytes + last
    send(hdr(2'd0, 6'h2A, 16'd6));
    chk("l6_data_type",   data_type, 32'h2A);
    chk("l6_word_count",  word_count, 6);
    chk("l6_in_line",     in_line, 1);
    chk("l6_wait",        wait_for_sync, 0);
    chk("l6_hdr_no_pe",   payload_enable, 0);
    send(32'h4433_2211);
    chk("l6_w1_pe",       payload_enable, 1);
    chk("l6_w1_dat",      payload, 32'h4433_2211);
    chk("l6_w1_bytes",    payload_bytes, 4);
    chk("l6_w1_last",     payload_last, 0);
    chk("l6_w1_done",     packet_done, 0);
    chk("l6_w1_wait",     wait_for_sync, 0);
    send(32'hA5A5_6655);
    chk("l6_w2_pe",       payload_enable, 1);
    chk("l6_w2_dat",      payload, 32'hA5A5_6655);
    chk("l6_w2_bytes",    payload_bytes, 2);
    chk("l6_w2_last",     payload_last, 1);
    chk("l6_done",        packet_done, 1);
    chk("l6_in_line_clr", in_line, 0);
    chk("l6_wait_back",   wait_for_sync, 1);
    idle();
    chk("l6_idle_pe",     payload_enable, 0);
    chk("l6_idle_done",   packet_done, 0);

    // Long WC=4: payload word held until the CRC-only word
    send(hdr(2'd0, 6'h2B, 16'd4));
    send(32'hDDCC_BBAA);
    chk("l4_w1_held",     payload_enable, 0);
    send(32'h0000_BEEF);
    chk("l4_pe",          payload_enable, 1);
    chk("l4_dat",         payload, 32'hDDCC_BBAA);
    chk("l4_bytes",       payload_bytes, 4);
    chk("l4_last",        payload_last, 1);
    chk("l4_done",        packet_done, 1);
    idle();
    chk("l4_idle_pe",     payload_enable, 0);

    // Long WC=10 on VC1: consumed silently, done after 3 words
    send(hdr(2'd1, 6'h2A, 16'd10));
    chk("vc1_word_count", word_count, 10);
    chk("vc1_in_line",    in_line, 0);
    for (int i = 0; i < 3; i++) begin
      send(32'h1234_0000 + i);
      chk("vc1_no_pe",    payload_enable, 0);
      chk("vc1_done",     packet_done, (i == 2) ? 1 : 0);
    end
    idle();

    // Abort after 1 of 3 words
    send(hdr(2'd0, 6'h2C, 16'd10));
    send(32'h1111_1111);
    chk("ab_w1_pe",       payload_enable, 1);
    chk("ab_w1_bytes",    payload_bytes, 4);
    chk("ab_w1_last",     payload_last, 0);
    idle();
    chk("ab_err_abort",   err_abort, 1);
    chk("ab_no_done",     packet_done, 0);
    chk("ab_wait",        wait_for_sync, 1);
    chk("ab_no_pe",       payload_enable, 0);
    idle();
    chk("ab_pulse_end",   err_abort, 0);

    // Line end short packet clears in_line
    send(hdr(2'd0, 6'h03, 16'd0));
    chk("le_in_line",     in_line, 0);
    chk("le_done",        packet_done, 1);
    idle();

    // Long WC=0: header plus CRC word, done only
    send(hdr(2'd0, 6'h2A, 16'd0));
    chk("wc0_word_count", word_count, 0);
    chk("wc0_in_line",    in_line, 1);
    send(32'h0000_CAFE);
    chk("wc0_no_pe",      payload_enable, 0);
    chk("wc0_done",       packet_done, 1);
    chk("wc0_in_line_clr", in_line, 0);
    idle();

    // Long WC=3: 3 payload bytes held, then CRC-only word
    send(hdr(2'd0, 6'h2A, 16'd3));
    send(32'h0033_2211);
    chk("wc3_held",       payload_enable, 0);
    send(32'h0000_0044);
    chk("wc3_pe",         payload_enable, 1);
    chk("wc3_bytes",      payload_bytes, 3);
    chk("wc3_last",       payload_last, 1);
    chk("wc3_done",       packet_done, 1);
    idle();

    // Frame end
    send(hdr(2'd0, 6'h01, 16'd0));
    chk("fe_in_frame",    in_frame, 0);
    chk("fe_vsync",       vsync, 0);
    chk("fe_data_type",   data_type, 1);
    idle();

`ifdef CSI_ECC_CHECK_EN
    // Flipped ECC bit: rejected, fields untouched
    send(hdr(2'd0, 6'h00, 16'd0) ^ 32'h0100_0000);
    chk("ecc_err",        err_ecc, 1);
    chk("ecc_done",       packet_done, 1);
    chk("ecc_data_type",  data_type, 1);
    chk("ecc_no_vsync",   vsync, 0);
    chk("ecc_in_frame",   in_frame, 0);
    idle();
    chk("ecc_pulse_end",  err_ecc, 0);
`else
    // ECC byte ignored: a bad ECC still updates state
    send(hdr(2'd0, 6'h02, 16'd0) ^ 32'h0100_0000);
    chk("noecc_err",      err_ecc, 0);
    chk("noecc_in_line",  in_line, 1);
    chk("noecc_done",     packet_done, 1);
    idle();
`endif

    // Reset mid-packet returns to reset values immediately
    send(hdr(2'd0, 6'h2A, 16'd6));
    chk("mr_wait_low",    wait_for_sync, 0);
    rst = 1'b1;
    de  = 1'b1;
    df  = 1'b1;
    dat = 32'h5555_5555;
    step();
    chk("mr_wait",        wait_for_sync, 1);
    chk("mr_data_type",   data_type, 0);
    chk("mr_pulses",      {packet_done, payload_enable, err_abort, in_line}, 0);
    rst = 1'b0;
    de  = 1'b0;
    df  = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
